// File: rtl/bp_burst_to_lite.sv
// bp_burst_to_lite: BedRock Burst (header + narrow beats) to one BedRock Lite message.
// Optional sticky error output enabled by defining BP_BURST_TO_LITE_ERR_EN.

package bp_burst_to_lite_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0,
        e_bp_small_cfg   = 1'b1
    } bp_params_e;

    function automatic int bp_paddr_width(bp_params_e cfg);
        int w;
        w = 40;
        if (cfg == e_bp_small_cfg) w = 32;
        return w;
    endfunction

endpackage

module bp_burst_to_lite
    import bp_burst_to_lite_pkg::*;
#(
    parameter bp_params_e  bp_params_p      = e_bp_default_cfg,
    parameter int          in_data_width_p  = 64,
    parameter int          out_data_width_p = 512,
    parameter int          payload_width_p  = 8,
    parameter logic [15:0] payload_mask_p   = '0,
    localparam int paddr_width_p       = bp_paddr_width(bp_params_p),
    localparam int in_msg_header_width = payload_width_p + 3 + paddr_width_p + 4,
    localparam int out_msg_width       = in_msg_header_width + out_data_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [in_msg_header_width-1:0] in_msg_header_i,
    input  logic                           in_msg_header_v_i,
    output logic                           in_msg_header_ready_and_o,
    input  logic [in_data_width_p-1:0]     in_msg_data_i,
    input  logic                           in_msg_data_v_i,
    output logic                           in_msg_data_ready_and_o,
    output logic [out_msg_width-1:0]       out_msg_o,
    output logic                           out_msg_v_o,
    input  logic                           out_msg_ready_and_i
`ifdef BP_BURST_TO_LITE_ERR_EN
    ,
    output logic                           err_o
`endif
);

    localparam int N        = out_data_width_p / in_data_width_p;
    localparam int CW       = (N > 1) ? $clog2(N) : 1;
    localparam int IN_BYTES = in_data_width_p / 8;

    if (out_data_width_p % in_data_width_p != 0) begin : g_chk_multiple
        $error("out_data_width_p must be a multiple of in_data_width_p");
    end
    if (out_data_width_p < in_data_width_p) begin : g_chk_order
        $error("out_data_width_p must be >= in_data_width_p");
    end

    typedef enum logic [2:0] {
        e_ready = 3'b001,
        e_data  = 3'b010,
        e_out   = 3'b100
    } state_e;

    state_e                         r_state;
    state_e                         w_state_nxt;
    logic [in_msg_header_width-1:0] r_header;
    logic [out_data_width_p-1:0]    r_data;
    logic [out_data_width_p-1:0]    w_data;
    logic [CW-1:0]                  r_count;
    logic [CW-1:0]                  r_last;
    logic                           r_full;
    logic [CW-1:0]                  w_idx;
    logic [3:0]                     w_type;
    logic [2:0]                     w_size;
    logic                           w_has_data;
    logic [31:0]                    w_raw;
    logic [31:0]                    w_beats;
    logic                           w_hdr_hs;
    logic                           w_data_hs;

    assign w_type     = in_msg_header_i[3:0];
    assign w_size     = in_msg_header_i[paddr_width_p+4 +: 3];
    assign w_has_data = payload_mask_p[w_type];
    assign w_raw      = (32'd1 << w_size) / 32'(IN_BYTES);
    assign w_hdr_hs   = in_msg_header_v_i & in_msg_header_ready_and_o;
    assign w_data_hs  = in_msg_data_v_i & in_msg_data_ready_and_o;

    // Beat count from header size: at least one, never more than fits the Lite word
    always_comb begin
        w_beats = w_raw;
        if (w_raw == 32'd0) begin
            w_beats = 32'd1;
        end else if (w_raw > 32'(N)) begin
            w_beats = 32'(N);
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_ready;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt               = r_state;
        in_msg_header_ready_and_o = 1'b0;
        in_msg_data_ready_and_o   = 1'b0;
        out_msg_v_o               = 1'b0;
        unique case (r_state)
            e_ready: begin
                in_msg_header_ready_and_o = 1'b1;
                if (in_msg_header_v_i) begin
                    w_state_nxt = w_has_data ? e_data : e_out;
                end
            end
            e_data: begin
                in_msg_data_ready_and_o = 1'b1;
                if (in_msg_data_v_i && (r_count == r_last)) begin
                    w_state_nxt = e_out;
                end
            end
            e_out: begin
                out_msg_v_o = 1'b1;
                if (out_msg_ready_and_i) begin
                    w_state_nxt = e_ready;
                end
            end
            default: w_state_nxt = e_ready;
        endcase
    end

    // Header latch and beat assembly
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_header <= '0;
            r_data   <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_hdr_hs) begin
                r_header <= in_msg_header_i;
                r_last   <= CW'(w_beats - 32'd1);
                r_full   <= (w_beats == 32'(N));
                r_count  <= '0;
                if (!w_has_data) begin
                    r_data <= '0;
                end
            end
            if (w_data_hs) begin
                r_data[r_count*in_data_width_p +: in_data_width_p] <= in_msg_data_i;
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Replicate received slots across the word; partial counts are powers of two
    always_comb begin
        w_data = '0;
        w_idx  = '0;
        for (int j = 0; j < N; j++) begin
            w_idx = r_full ? CW'(j) : (CW'(j) & r_last);
            w_data[j*in_data_width_p +: in_data_width_p] =
                r_data[w_idx*in_data_width_p +: in_data_width_p];
        end
    end

    assign out_msg_o = {r_header, w_data};

`ifdef BP_BURST_TO_LITE_ERR_EN
    logic r_err;
    logic w_clamp;
    logic w_err_set;

    assign w_clamp   = (w_raw > 32'(N));
    assign w_err_set = w_hdr_hs & ((~w_has_data & in_msg_data_v_i) | w_clamp);
    assign err_o     = r_err;

    // Sticky protocol error flag, cleared only by reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_burst_to_lite.sv
// tb_bp_burst_to_lite: directed and random Burst messages against a reference model.
// Error-port checks are active when BP_BURST_TO_LITE_ERR_EN is defined.

module tb_bp_burst_to_lite;

    localparam int IN_W    = 64;
    localparam int OUT_W   = 512;
    localparam int N       = OUT_W / IN_W;
    localparam int PAY_W   = 8;
    localparam int PADDR_W = 40;
    localparam int HDR_W   = PAY_W + 3 + PADDR_W + 4;
    localparam int MSG_W   = HDR_W + OUT_W;
    localparam logic [15:0] MASK = 16'h00AA;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [HDR_W-1:0] in_msg_header_i = '0;
    logic             in_msg_header_v_i = 1'b0;
    logic             in_msg_header_ready_and_o;
    logic [IN_W-1:0]  in_msg_data_i = '0;
    logic             in_msg_data_v_i = 1'b0;
    logic             in_msg_data_ready_and_o;
    logic [MSG_W-1:0] out_msg_o;
    logic             out_msg_v_o;
    logic             out_msg_ready_and_i = 1'b0;
`ifdef BP_BURST_TO_LITE_ERR_EN
    logic             err;
`endif

    bp_burst_to_lite #(
        .in_data_width_p (IN_W),
        .out_data_width_p(OUT_W),
        .payload_width_p (PAY_W),
        .payload_mask_p  (MASK)
    ) dut (
        .clk_i                    (clk),
        .reset_n_i                (reset_n),
        .in_msg_header_i          (in_msg_header_i),
        .in_msg_header_v_i        (in_msg_header_v_i),
        .in_msg_header_ready_and_o(in_msg_header_ready_and_o),
        .in_msg_data_i            (in_msg_data_i),
        .in_msg_data_v_i          (in_msg_data_v_i),
        .in_msg_data_ready_and_o  (in_msg_data_ready_and_o),
        .out_msg_o                (out_msg_o),
        .out_msg_v_o              (out_msg_v_o),
        .out_msg_ready_and_i      (out_msg_ready_and_i)
`ifdef BP_BURST_TO_LITE_ERR_EN
        ,
        .err_o                    (err)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] beat_q[$];

    task automatic chk(input string tag, input logic [MSG_W-1:0] obs,
                       input logic [MSG_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int ref_beats(input int sz);
        int b;
        b = (1 << sz) / (IN_W / 8);
        if (b < 1) b = 1;
        if (b > N) b = N;
        return b;
    endfunction

    task automatic run_msg(input logic [3:0] ty, input logic [2:0] sz,
                           input logic [39:0] ad, input logic [7:0] pl,
                           input int gap_pct, input int stall,
                           input bit chk_lat, input bit early);
        logic [HDR_W-1:0] hdr;
        logic [OUT_W-1:0] exp_d;
        logic [MSG_W-1:0] first;
        int nb, rb, sent, t0, wc;
        bit has, v, acc;
        hdr = {pl, sz, ad, ty};
        has = MASK[ty];
        rb  = ref_beats(int'(sz));
        nb  = has ? rb : 0;
        while (beat_q.size() < nb) beat_q.push_back({$urandom, $urandom});
        exp_d = '0;
        if (has) begin
            for (int j = 0; j < N; j++) exp_d[j*IN_W +: IN_W] = beat_q[j % rb];
        end
        in_msg_header_i   = hdr;
        in_msg_header_v_i = 1'b1;
        if (early) begin
            in_msg_data_v_i = 1'b1;
            in_msg_data_i   = has ? beat_q[0] : {$urandom, $urandom};
        end
        wc = 0;
        while (!in_msg_header_ready_and_o && wc < 20) begin
            tick();
            wc++;
        end
        chk("hdr_ready", MSG_W'(in_msg_header_ready_and_o), MSG_W'(1));
        if (early) chk("early_beat_blocked", MSG_W'(in_msg_data_ready_and_o), MSG_W'(0));
        tick();
        t0 = cyc;
        in_msg_header_v_i = 1'b0;
        in_msg_header_i   = HDR_W'({$urandom, $urandom});
        in_msg_data_v_i   = 1'b0;
`ifdef BP_BURST_TO_LITE_ERR_EN
        if (early && !has) chk("err_set", MSG_W'(err), MSG_W'(1));
`endif
        sent = 0;
        wc   = 0;
        while (sent < nb && wc < 400) begin
            v = ($urandom_range(99) >= gap_pct);
            in_msg_data_v_i = v;
            in_msg_data_i   = v ? beat_q[sent] : {$urandom, $urandom};
            acc = v && in_msg_data_ready_and_o;
            chk("no_out_in_data", MSG_W'(out_msg_v_o), MSG_W'(0));
            chk("hdr_ready_in_data", MSG_W'(in_msg_header_ready_and_o), MSG_W'(0));
            tick();
            if (acc) sent++;
            wc++;
        end
        in_msg_data_v_i = 1'b0;
        chk("beats_taken", MSG_W'(sent), MSG_W'(nb));
        wc = 0;
        while (!out_msg_v_o && wc < 20) begin
            tick();
            wc++;
        end
        chk("out_valid", MSG_W'(out_msg_v_o), MSG_W'(1));
        if (chk_lat) chk("latency", MSG_W'(cyc - t0), MSG_W'(nb));
        chk("out_msg", out_msg_o, {hdr, exp_d});
        first = out_msg_o;
        for (int s = 0; s < stall; s++) begin
            out_msg_ready_and_i = 1'b0;
            in_msg_data_v_i     = 1'b1;
            in_msg_data_i       = {$urandom, $urandom};
            in_msg_header_v_i   = 1'b1;
            chk("stall_valid", MSG_W'(out_msg_v_o), MSG_W'(1));
            chk("stall_hdr_ready", MSG_W'(in_msg_header_ready_and_o), MSG_W'(0));
            chk("stall_data_ready", MSG_W'(in_msg_data_ready_and_o), MSG_W'(0));
            tick();
            chk("stall_stable", out_msg_o, first);
        end
        in_msg_header_v_i   = 1'b0;
        in_msg_data_v_i     = 1'b0;
        out_msg_ready_and_i = 1'b1;
        tick();
        out_msg_ready_and_i = 1'b0;
        chk("out_drop", MSG_W'(out_msg_v_o), MSG_W'(0));
        chk("back_to_ready", MSG_W'(in_msg_header_ready_and_o), MSG_W'(1));
        beat_q.delete();
    endtask

    initial begin
        int gap;
        // reset state
        repeat (3) tick();
        chk("rst_out_v", MSG_W'(out_msg_v_o), MSG_W'(0));
        chk("rst_hdr_ready", MSG_W'(in_msg_header_ready_and_o), MSG_W'(1));
        chk("rst_data_ready", MSG_W'(in_msg_data_ready_and_o), MSG_W'(0));
        reset_n = 1'b1;
        tick();

        // header-only, 8B
        run_msg(4'h0, 3'd3, 40'h12_3456_7890, 8'h5A, 0, 0, 1'b1, 1'b0);
`ifdef BP_BURST_TO_LITE_ERR_EN
        chk("err_clean", MSG_W'(err), MSG_W'(0));
`endif

        // full 64B burst, beat i = i*0x1111
        for (int i = 0; i < N; i++) beat_q.push_back(64'(i * 32'h1111));
        run_msg(4'h1, 3'd6, 40'h00_0000_1000, 8'h11, 0, 0, 1'b1, 1'b0);

        // 2B sub-width: one beat replicated, extra beats refused
        beat_q.push_back(64'h0000_0000_0000_BEEF);
        run_msg(4'h3, 3'd1, 40'h00_0000_2002, 8'h22, 0, 3, 1'b1, 1'b1);

        // gaps plus 5-cycle output backpressure
        run_msg(4'h5, 3'd6, 40'hFF_0000_0040, 8'h33, 50, 5, 1'b0, 1'b0);

        // reset after beat 3 of 8: partial message is dropped
        in_msg_header_i   = {8'h77, 3'd6, 40'hAB_CDEF_0100, 4'h1};
        in_msg_header_v_i = 1'b1;
        tick();
        in_msg_header_v_i = 1'b0;
        chk("rst_mid_in_data", MSG_W'(in_msg_data_ready_and_o), MSG_W'(1));
        for (int i = 0; i < 3; i++) begin
            in_msg_data_v_i = 1'b1;
            in_msg_data_i   = {$urandom, $urandom};
            tick();
        end
        in_msg_data_v_i = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_v", MSG_W'(out_msg_v_o), MSG_W'(0));
        chk("rst_mid_hdr_ready", MSG_W'(in_msg_header_ready_and_o), MSG_W'(1));
        chk("rst_mid_data_ready", MSG_W'(in_msg_data_ready_and_o), MSG_W'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_mid_no_emit", MSG_W'(out_msg_v_o), MSG_W'(0));
        run_msg(4'h1, 3'd6, 40'h00_0000_3000, 8'h44, 0, 0, 1'b1, 1'b0);

`ifdef BP_BURST_TO_LITE_ERR_EN
        // data valid alongside a payload-less header
        run_msg(4'h0, 3'd3, 40'h00_0000_4000, 8'h55, 0, 0, 1'b1, 1'b1);
        repeat (3) tick();
        chk("err_sticky", MSG_W'(err), MSG_W'(1));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("err_cleared", MSG_W'(err), MSG_W'(0));
`endif

        // random traffic
        for (int k = 0; k < 40; k++) begin
            gap = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(60));
            run_msg(4'($urandom_range(15)), 3'($urandom_range(7)),
                    {8'($urandom), $urandom}, 8'($urandom),
                    gap, int'($urandom_range(4)), (gap == 0),
                    1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
